// File: rtl/tag_check_2way_if.sv
// Bundle for the 2-way tag checker: request handshake, shared tag RAM port pair
// and the one-cycle response pulse.
interface tag_check_2way_if #(
    parameter int AWIDTH = 3,
    parameter int TWIDTH = 12
);
    localparam int DWIDTH = TWIDTH + 2;

    // A request transfers on a rising edge where req_valid and req_ready are both 1;
    // req_ready is high only while idle, and the response has no backpressure.
    logic              req_valid;
    logic              req_ready;
    logic [AWIDTH-1:0] req_index;
    logic [TWIDTH-1:0] req_tag;
    logic              req_write;

    logic [AWIDTH-1:0] t_addr;
    logic              t0_we;
    logic              t1_we;
    logic [DWIDTH-1:0] t0_din;
    logic [DWIDTH-1:0] t1_din;
    logic [DWIDTH-1:0] t0_dout;
    logic [DWIDTH-1:0] t1_dout;

    logic              rsp_valid;
    logic              rsp_hit;
    logic              rsp_way;
    logic              rsp_evict;
    logic [TWIDTH-1:0] rsp_evict_tag;

    modport master (
        output req_valid, req_index, req_tag, req_write, t0_dout, t1_dout,
        input  req_ready, t_addr, t0_we, t1_we, t0_din, t1_din,
        input  rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_tag
    );

    modport slave (
        input  req_valid, req_index, req_tag, req_write, t0_dout, t1_dout,
        output req_ready, t_addr, t0_we, t1_we, t0_din, t1_din,
        output rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_tag
    );
endinterface

// File: rtl/tag_check_2way.sv
// Lookup/allocate controller for a 2-way set-associative cache: compares both tag
// RAM entries, tracks per-set LRU and writes the victim way on a miss.
module tag_check_2way #(
    parameter int AWIDTH = 3,
    parameter int TWIDTH = 12
) (
    input  logic                 clock,
    input  logic                 reset_n,
    tag_check_2way_if.slave      bus,
    output logic [1:0]           dbg_state,
    output logic [2**AWIDTH-1:0] dbg_lru
);
    localparam int DWIDTH = TWIDTH + 2;
    localparam int DEPTH  = 2 ** AWIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMP   = 2'd1,
        ALLOC = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [AWIDTH-1:0] idx_q;
    logic [TWIDTH-1:0] tag_q;
    logic              wr_q;
    logic              hit_q;
    logic              way_q;
    logic              evict_q;
    logic [TWIDTH-1:0] evict_tag_q;
    logic [DEPTH-1:0]  lru;

    logic              valid0;
    logic              valid1;
    logic              hit0;
    logic              hit1;
    logic              hit;
    logic              victim;
    logic [DWIDTH-1:0] victim_entry;

    // Compare path: tag RAM data is valid in CMP, one cycle after the index was sampled.
    always_comb begin
        valid0       = bus.t0_dout[DWIDTH-1];
        valid1       = bus.t1_dout[DWIDTH-1];
        hit0         = valid0 && (bus.t0_dout[TWIDTH-1:0] == tag_q);
        hit1         = valid1 && (bus.t1_dout[TWIDTH-1:0] == tag_q);
        hit          = hit0 || hit1;
        if (!valid0) begin
            victim = 1'b0;
        end else if (!valid1) begin
            victim = 1'b1;
        end else begin
            victim = lru[idx_q];
        end
        victim_entry = victim ? bus.t1_dout : bus.t0_dout;
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.req_valid) state_nxt = CMP;
            CMP:     state_nxt = hit ? RESP : ALLOC;
            ALLOC:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, compare result and LRU
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q       <= '0;
            tag_q       <= '0;
            wr_q        <= 1'b0;
            hit_q       <= 1'b0;
            way_q       <= 1'b0;
            evict_q     <= 1'b0;
            evict_tag_q <= '0;
            lru         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        idx_q <= bus.req_index;
                        tag_q <= bus.req_tag;
                        wr_q  <= bus.req_write;
                    end
                end
                CMP: begin
                    hit_q <= hit;
                    if (hit) begin
                        // Way 0 wins when both ways hold the tag.
                        way_q       <= !hit0;
                        evict_q     <= 1'b0;
                        evict_tag_q <= '0;
                        lru[idx_q]  <= hit0;
                    end else begin
                        way_q       <= victim;
                        evict_q     <= victim_entry[DWIDTH-1] && victim_entry[DWIDTH-2];
                        evict_tag_q <= victim_entry[DWIDTH-1] ? victim_entry[TWIDTH-1:0] : '0;
                    end
                end
                ALLOC: begin
                    lru[idx_q] <= !way_q;
                end
                RESP: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Output logic: write data is shared by both ways; only the enables differ.
    always_comb begin
        bus.req_ready     = (state == IDLE);
        bus.t_addr        = (state == IDLE) ? bus.req_index : idx_q;
        bus.t0_we         = 1'b0;
        bus.t1_we         = 1'b0;
        bus.t0_din        = {1'b1, wr_q, tag_q};
        bus.t1_din        = {1'b1, wr_q, tag_q};
        bus.rsp_valid     = 1'b0;
        bus.rsp_hit       = 1'b0;
        bus.rsp_way       = 1'b0;
        bus.rsp_evict     = 1'b0;
        bus.rsp_evict_tag = '0;
        unique case (state)
            IDLE: begin
            end
            CMP: begin
                if (hit && wr_q) begin
                    bus.t0_we = hit0;
                    bus.t1_we = !hit0;
                end
            end
            ALLOC: begin
                bus.t0_we = !way_q;
                bus.t1_we = way_q;
            end
            RESP: begin
                bus.rsp_valid     = 1'b1;
                bus.rsp_hit       = hit_q;
                bus.rsp_way       = way_q;
                bus.rsp_evict     = evict_q;
                bus.rsp_evict_tag = evict_tag_q;
            end
            default: begin
            end
        endcase
    end

    assign dbg_state = state;
    assign dbg_lru   = lru;
endmodule
